// File: rtl/prog_rom_pkg.sv
// Shared definitions for the program ROM arbiter: size defaults, starvation
// limit and the service-state encoding.
package prog_rom_pkg;

   localparam int ROM_ADDR_W     = 12;
   localparam int ROM_DATA_W     = 8;
   localparam int ROM_STARVE_MAX = 4;
   localparam int STARVE_CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      RD_CORE,
      RD_HOST,
      WR_HOST
   } arb_state_t;

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of core wins taken while the host is waiting; asks for a
// forced host slot once the limit is reached.
module rom_arb_starve_ctr
   import prog_rom_pkg::*;
#(
   parameter int STARVE_MAX = ROM_STARVE_MAX
) (
   input  logic clk,
   input  logic res,
   input  logic host_req,
   input  logic core_win,
   input  logic host_win,
   output logic force_host
);

   localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] starve_cnt;

   assign force_host = host_req && (starve_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (res) begin
         starve_cnt <= '0;
      end else if (host_win || !host_req) begin
         starve_cnt <= '0;
      end else if (core_win && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/prog_rom_arbiter.sv
// Arbitrates the single-port program memory between the core fetch path
// (priority) and the host load/patch port, one access per cycle.
module prog_rom_arbiter
   import prog_rom_pkg::*;
#(
   parameter int ADDR_W     = ROM_ADDR_W,
   parameter int DATA_W     = ROM_DATA_W,
   parameter int STARVE_MAX = ROM_STARVE_MAX
) (
   input  logic              clk,
   input  logic              res,
   input  logic              core_req,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_gnt,
   output logic              core_valid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_valid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   input  logic              lock,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state;
   logic              force_host;
   logic              core_win;
   logic              host_win;
   logic              host_rd_win;
   logic              host_wr_win;
   logic              host_rej;
   logic              rej_p1;
   logic              host_rd_p2;
   logic [DATA_W-1:0] core_rdata_p2;
   logic [DATA_W-1:0] host_rdata_p2;

   rom_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk        (clk),
      .res        (res),
      .host_req   (host_req),
      .core_win   (core_win),
      .host_win   (host_win),
      .force_host (force_host)
   );

   always_comb begin
      host_win    = force_host || (host_req && !core_req);
      core_win    = core_req && !force_host;
      host_rd_win = host_win && !host_we;
      host_wr_win = host_win && host_we && !lock;
      host_rej    = host_win && host_we && lock;
   end

   // Stage boundary: arbitration at E drives the memory cycle in E+1, and the
   // state of that cycle produces the completion pulse in E+2.
   always_ff @(posedge clk) begin
      if (res) begin
         state         <= IDLE;
         core_gnt      <= 1'b0;
         host_gnt      <= 1'b0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         rej_p1        <= 1'b0;
         core_valid    <= 1'b0;
         host_valid    <= 1'b0;
         host_err      <= 1'b0;
         host_rd_p2    <= 1'b0;
         core_rdata_p2 <= '0;
         host_rdata_p2 <= '0;
      end else begin
         core_gnt  <= core_win;
         host_gnt  <= host_win;
         mem_en    <= core_win || host_rd_win || host_wr_win;
         mem_we    <= host_wr_win;
         mem_wdata <= host_wr_win ? host_wdata : '0;
         rej_p1    <= host_rej;

         if (core_win) begin
            mem_addr <= core_addr;
            state    <= RD_CORE;
         end else if (host_rd_win) begin
            mem_addr <= host_addr;
            state    <= RD_HOST;
         end else if (host_wr_win) begin
            mem_addr <= host_addr;
            state    <= WR_HOST;
         end else begin
            mem_addr <= '0;
            state    <= IDLE;
         end

         core_valid <= 1'b0;
         host_valid <= rej_p1;
         host_err   <= rej_p1;
         host_rd_p2 <= 1'b0;
         case (state)
            RD_CORE: core_valid <= 1'b1;
            RD_HOST: begin
               host_valid <= 1'b1;
               host_rd_p2 <= 1'b1;
            end
            WR_HOST: host_valid <= 1'b1;
            default: ;
         endcase

         if (core_valid) core_rdata_p2 <= mem_rdata;
         if (host_rd_p2) host_rdata_p2 <= mem_rdata;
      end
   end

   // The memory's registered output is live during the valid cycle; the
   // holding registers keep the value afterwards until the next read completes.
   assign core_rdata = core_valid ? mem_rdata : core_rdata_p2;
   assign host_rdata = host_rd_p2 ? mem_rdata : host_rdata_p2;

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Randomized scoreboard bench for prog_rom_arbiter with a behavioural ROM and
// a reference memory image updated in grant order.
module tb_prog_rom_arbiter;
   import prog_rom_pkg::*;

   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 8;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              res = 1'b1;
   logic              core_req = 1'b0;
   logic [ADDR_W-1:0] core_addr = '0;
   logic              core_gnt, core_valid;
   logic [DATA_W-1:0] core_rdata;
   logic              host_req = 1'b0;
   logic              host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic              host_gnt, host_valid, host_err;
   logic [DATA_W-1:0] host_rdata;
   logic              lock = 1'b0;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   always #5 clk = ~clk;

   prog_rom_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .res        (res),
      .core_req   (core_req),
      .core_addr  (core_addr),
      .core_gnt   (core_gnt),
      .core_valid (core_valid),
      .core_rdata (core_rdata),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_gnt   (host_gnt),
      .host_valid (host_valid),
      .host_rdata (host_rdata),
      .host_err   (host_err),
      .lock       (lock),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   typedef struct {
      logic       rd;
      logic [7:0] data;
      logic       err;
      int         due;
   } rsp_t;

   rsp_t       core_q[$];
   rsp_t       host_q[$];
   rsp_t       mon_c, mon_h;
   logic [7:0] ref_mem [4096];
   logic [7:0] rom [4096];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         wait_cnt = 0;
   int         n_core_gnt = 0;
   int         core_mode = 0;
   int         host_mode = 0;
   bit         core_done, host_done;
   logic [ADDR_W-1:0] auto_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input int i);
      if (i < 4) return 8'(8'hA0 + i);
      if (i == 'h3FF) return 8'h5A;
      return 8'((i * 29 + 7) ^ (i >> 4));
   endfunction

   // Synchronous single-port program memory, one-cycle read latency.
   initial begin
      mem_rdata = '0;
      for (int i = 0; i < 4096; i++) rom[i] = init_byte(i);
      forever begin
         @(posedge clk);
         if (mem_en) begin
            if (mem_we) rom[mem_addr] <= mem_wdata;
            else        mem_rdata <= rom[mem_addr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [ADDR_W-1:0] raddr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) return 12'h3FF;
      if (r == 1) return 12'h300;
      return 12'($urandom_range(0, 15));
   endfunction

   task automatic gen();
      if (core_mode == 1 && !core_req) begin
         core_req  = 1'b1;
         core_addr = auto_addr;
         auto_addr = auto_addr + 12'd1;
      end else if (core_mode == 2) begin
         if (core_req) begin
            if ($urandom_range(0, 19) == 0) core_req = 1'b0;
         end else if ($urandom_range(0, 3) != 0) begin
            core_req  = 1'b1;
            core_addr = raddr();
         end
      end
      if (host_mode == 2) begin
         if (host_req) begin
            if ($urandom_range(0, 29) == 0) host_req = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            host_req   = 1'b1;
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = raddr();
            host_wdata = 8'($urandom);
         end
         if ($urandom_range(0, 9) == 0) lock = ~lock;
      end
   endtask

   // One clock: predict the winner of the edge just taken from the inputs that
   // were presented to it, check grant and memory strobes, then drive anew.
   task automatic cycle();
      bit eh, ec, hw, hacc;
      @(negedge clk);
      if (res) begin
         core_q.delete();
         host_q.delete();
         wait_cnt = 0;
         check("reset_ctrl", 32'({core_gnt, core_valid, host_gnt, host_valid, host_err, mem_en, mem_we}), 0);
         check("reset_data", 32'({core_rdata, host_rdata, mem_wdata}), 0);
         check("reset_addr", 32'(mem_addr), 0);
         return;
      end
      eh   = host_req && (wait_cnt == STARVE_MAX || !core_req);
      ec   = core_req && !eh;
      hw   = eh && host_we && !lock;
      hacc = eh && !(host_we && lock);
      check("core_gnt", 32'(core_gnt), 32'(ec));
      check("host_gnt", 32'(host_gnt), 32'(eh));
      check("mem_en", 32'(mem_en), 32'(ec || hacc));
      check("mem_we", 32'(mem_we), 32'(hw));
      if (ec) check("mem_addr_core", 32'(mem_addr), 32'(core_addr));
      else if (hacc) check("mem_addr_host", 32'(mem_addr), 32'(host_addr));
      if (hw) check("mem_wdata", 32'(mem_wdata), 32'(host_wdata));
      // Core grants since the host's request became pending.
      if (eh || !host_req) wait_cnt = 0;
      else if (ec) wait_cnt = wait_cnt + 1;
      if (ec) begin
         core_q.push_back('{rd: 1'b1, data: ref_mem[core_addr], err: 1'b0, due: cyc + 1});
         core_req  = 1'b0;
         core_done = 1'b1;
         n_core_gnt++;
      end
      if (eh) begin
         if (host_we) begin
            if (!lock) ref_mem[host_addr] = host_wdata;
            host_q.push_back('{rd: 1'b0, data: 8'h00, err: lock, due: cyc + 1});
         end else begin
            host_q.push_back('{rd: 1'b1, data: ref_mem[host_addr], err: 1'b0, due: cyc + 1});
         end
         host_req  = 1'b0;
         host_done = 1'b1;
      end
      gen();
   endtask

   task automatic core_read(input logic [ADDR_W-1:0] a);
      core_req  = 1'b1;
      core_addr = a;
      core_done = 1'b0;
      for (int i = 0; i < 40 && !core_done; i++) cycle();
      if (!core_done) check("core_gnt_timeout", 32'(core_done), 1);
   endtask

   task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int core_seen);
      int start;
      start      = n_core_gnt;
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = a;
      host_wdata = d;
      host_done  = 1'b0;
      for (int i = 0; i < 40 && !host_done; i++) cycle();
      if (!host_done) check("host_gnt_timeout", 32'(host_done), 1);
      core_seen = n_core_gnt - start;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Response monitor: pops the scoreboard whenever a completion is presented.
   always @(negedge clk) begin
      if (core_valid) begin
         if (core_q.size() == 0) begin
            check("core_valid_unexpected", 32'(core_valid), 0);
         end else begin
            mon_c = core_q.pop_front();
            check("core_rdata", 32'(core_rdata), 32'(mon_c.data));
            check("core_valid_cycle", 32'(cyc), 32'(mon_c.due));
         end
      end else if (core_q.size() > 0 && core_q[0].due < cyc) begin
         check("core_valid_missing", 32'(cyc), 32'(core_q[0].due));
         core_q.delete(0);
      end
      if (host_valid) begin
         if (host_q.size() == 0) begin
            check("host_valid_unexpected", 32'(host_valid), 0);
         end else begin
            mon_h = host_q.pop_front();
            check("host_err", 32'(host_err), 32'(mon_h.err));
            check("host_valid_cycle", 32'(cyc), 32'(mon_h.due));
            if (mon_h.rd) check("host_rdata", 32'(host_rdata), 32'(mon_h.data));
         end
      end else begin
         check("host_err_no_valid", 32'(host_err), 0);
         if (host_q.size() > 0 && host_q[0].due < cyc) begin
            check("host_valid_missing", 32'(cyc), 32'(host_q[0].due));
            host_q.delete(0);
         end
      end
   end

   initial begin
      int seen;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

      // Reset held two cycles with both requesters asserting.
      res = 1'b1; core_req = 1'b1; host_req = 1'b1;
      core_addr = 12'h001; host_addr = 12'h002;
      drain(2);
      res = 1'b0; core_req = 1'b0; host_req = 1'b0;
      drain(2);

      // Core-only burst, new address presented at each grant.
      for (int a = 0; a < 4; a++) core_read(12'(a));
      drain(4);

      // Continuous core traffic against one host read.
      core_mode = 1;
      auto_addr = 12'h010;
      cycle();
      host_op(1'b0, 12'h3FF, 8'h00, seen);
      check("starve_core_grants", 32'(seen), STARVE_MAX);
      drain(3);
      core_mode = 0;
      core_req  = 1'b0;
      drain(4);

      // Unlocked write and readback, then a write rejected by lock.
      lock = 1'b0;
      host_op(1'b1, 12'h300, 8'hC3, seen);
      host_op(1'b0, 12'h300, 8'h00, seen);
      lock = 1'b1;
      host_op(1'b1, 12'h300, 8'hFF, seen);
      host_op(1'b0, 12'h300, 8'h00, seen);
      lock = 1'b0;
      drain(4);

      // Reset while a core read is in its memory cycle.
      core_read(12'h3FF);
      res = 1'b1;
      cycle();
      res = 1'b0;
      drain(3);
      core_read(12'h002);
      drain(4);

      // Randomized traffic: saturating core load, then mixed load.
      core_mode = 1; host_mode = 2;
      drain(600);
      core_mode = 2;
      drain(2000);
      core_mode = 0; host_mode = 0;
      core_req = 1'b0; host_req = 1'b0; lock = 1'b0;
      drain(6);

      check("core_q_empty", 32'(core_q.size()), 0);
      check("host_q_empty", 32'(host_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prog_rom_arbiter.md
Name: prog_rom_arbiter

Overview:
Shares the single 4 KB program ROM between the i8048 core fetch path and a host/debug port used to load, patch and read back the 89KLR_951 image. Core fetches (opcode, operand, MOVP/MOVP3 table reads) take priority. A starvation counter guarantees host progress. It drives a synchronous single-port ROM/RAM with one-cycle read latency and sits between the core address mux and the program memory.

Parameters:
ADDR_W, 12, program memory address width (4096 bytes)
DATA_W, 8, program memory data width
STARVE_MAX, 4, consecutive core grants with host pending before the host is forced a slot (range 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
res  in  1  synchronous reset, active-high
core_req  in  1  core read request, held until core_gnt
core_addr  in  ADDR_W  core read address
core_gnt  out  1  one-cycle pulse: core request accepted
core_valid  out  1  one-cycle pulse: core_rdata valid
core_rdata  out  DATA_W  core read data, held until next core_valid
host_req  in  1  host request, held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse: host request accepted
host_valid  out  1  one-cycle pulse: host access complete (read data valid or write done)
host_rdata  out  DATA_W  host read data, held until next host_valid
host_err  out  1  pulses with host_valid when a write was rejected by lock
lock  in  1  1 = host writes blocked, host reads allowed
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe (only with mem_en)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (res=1 at edge): state IDLE; all outputs 0, including mem_*, gnt, valid, err, rdata; starve_cnt=0. Reset mid-access drops the in-flight access, and no valid is issued afterwards.
- FSM states: IDLE, RD_CORE, RD_HOST, WR_HOST. Arbitration runs at every edge from any state, so back-to-back accesses run at 1 per cycle.
- Arbitration at edge E, in priority order:
  - host_req=1 and starve_cnt==STARVE_MAX: host wins.
  - Otherwise core_req=1: core wins.
  - Otherwise host_req=1: host wins.
  - Otherwise: IDLE.
- Winner handling:
  - Core winner: next state RD_CORE.
  - Host winner, host_we=0: next state RD_HOST.
  - Host winner, host_we=1, lock=0: next state WR_HOST.
  - Host winner, host_we=1, lock=1: next state IDLE, no memory cycle; host_gnt pulses in cycle E+1, and host_valid plus host_err pulse in cycle E+2.
- Grant: the gnt pulse is registered and high in the cycle after edge E. Address and data are captured at E. Requesters may drop req at the gnt edge or issue a new request immediately. Dropping req before gnt cancels it with no side effects.
- Memory outputs are registered and valid during the service state: mem_en=1, mem_addr = captured address, mem_we=1 only in WR_HOST. In IDLE, mem_en=0 and mem_we=0.
- Latency: request sampled at E, gnt and mem_en in E+1, valid and rdata in E+2 (capture of mem_rdata at edge E+2). Write: host_valid in E+2, and the ROM is updated at edge E+2.
- Starvation counter (4 bits):
  - Increments on each core win while host_req=1, saturating at STARVE_MAX.
  - Clears on a host win or whenever host_req=0.
- Simultaneous core_req and host_req with starve_cnt<STARVE_MAX: core wins, and the counter increments.
- lock changes take effect at the arbitration edge only. A WR_HOST already granted completes even if lock rises afterwards.
- Address wrap is not applicable; ADDR_W covers all of memory, and no range checks are made.

Decomposition:
- Package prog_rom_pkg holds ADDR_W/DATA_W defaults, the state enum (IDLE, RD_CORE, RD_HOST, WR_HOST) and STARVE_MAX default.
- One sub-module, rom_arb_starve_ctr: the saturating starvation counter with a force_host output. Everything else stays in prog_rom_arbiter.
- The ROM model stays outside this block.

Test Plan:
- Reset: res=1 for 2 cycles with both requests high -> all outputs 0, no gnt/valid during reset or in the first cycle after release.
- Core-only burst: core_req held, addresses 0x000..0x003 changed each gnt, ROM preloaded with 0xA0..0xA3 -> core_valid every cycle from E+2 with rdata A0, A1, A2, A3, and mem_we never high.
- Contention: core_req held continuously, host read at 0x3FF (ROM=0x5A), STARVE_MAX=4 -> exactly 4 core grants, then host_gnt, then host_valid with rdata=0x5A two cycles after the host win, then core resumes.
- Host write, unlocked: lock=0, write 0xC3 to 0x300, then host read 0x300 -> mem_we pulse with addr 0x300 and data 0xC3; readback 0xC3; host_err=0.
- Locked write: lock=1, write 0xFF to 0x300 -> host_gnt and host_valid+host_err pulse, mem_en stays 0, readback still 0xC3.
- Reset mid-access: res=1 in the cycle RD_CORE is active -> no core_valid follows, outputs return to 0, and a fresh core_req after release completes normally.
